// File: rtl/aes_dec_sched_if.sv
// Block stream between the DMA/stream glue and the decipher scheduler.
//   master : drives ciphertext (in_valid/in_data) and out_ready,
//            observes in_ready, out_valid, out_data
//   slave  : the scheduler side, the mirror image of master
interface aes_dec_sched_if #(
  parameter int BLK_S = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [BLK_S-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_S-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_dec_sched.sv
// Sequencing controller for the iterative AES-128 decipher core.
// Holds the round-key store, accepts one ciphertext block at a time, starts
// the core, serves round keys by round number, applies optional CBC chaining
// and returns plaintext.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rk_we/addr/data     round-key store write (IDLE only)
//   key_done/key_ready  key store complete / keys valid
//   iv_we/iv_data       chain register load (IDLE only)
//   cbc_en              1=CBC, 0=ECB, sampled at block acceptance
//   strm                ciphertext in / plaintext out valid-ready streams
//   dec_*               decipher core interface
//   err                 sticky: write outside IDLE or core timeout
//
// state | meaning
// IDLE  | waiting for a block; key/IV writes allowed
// START | dec_en pulse to the core
// BUSY  | core running, timeout counter advancing
// OUT   | plaintext presented, waiting for out_ready
module aes_dec_sched #(
  parameter int BLK_S   = 128,
  parameter int NR      = 10,
  parameter int RN_W    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rk_we,
  input  logic [RN_W-1:0]   rk_addr,
  input  logic [BLK_S-1:0]  rk_data,
  input  logic              key_done,
  output logic              key_ready,
  input  logic              iv_we,
  input  logic [BLK_S-1:0]  iv_data,
  input  logic              cbc_en,
  aes_dec_sched_if.slave    strm,
  output logic              dec_en,
  output logic [BLK_S-1:0]  dec_ct,
  input  logic [RN_W-1:0]   dec_round_no,
  output logic [BLK_S-1:0]  dec_round_key,
  input  logic [BLK_S-1:0]  dec_pt,
  input  logic              dec_done,
  output logic              err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, OUT} state_t;

  state_t             state;
  logic [BLK_S-1:0]   key_mem [NR+1];
  logic [BLK_S-1:0]   chain;
  logic [BLK_S-1:0]   ct_reg;
  logic [BLK_S-1:0]   out_data_r;
  logic               out_valid_r;
  logic               mode_reg;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               any_wr;

  assign strm.in_ready  = (state == IDLE) && key_ready && !reset;
  assign accept         = strm.in_valid && strm.in_ready;
  assign strm.out_valid = out_valid_r;
  assign strm.out_data  = out_data_r;
  assign dec_ct         = ct_reg;
  assign any_wr         = rk_we || iv_we || key_done;

  // Key store survives reset; key_ready=0 after reset forces a reload.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && rk_we && rk_addr <= RN_W'(NR))
      key_mem[rk_addr] <= rk_data;
  end

  // Served every cycle so the core sees key[n] one cycle after asking for n.
  always_ff @(posedge clk) begin
    if (dec_round_no <= RN_W'(NR))
      dec_round_key <= key_mem[dec_round_no];
    else
      dec_round_key <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key_ready   <= 1'b0;
      dec_en      <= 1'b0;
      err         <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      chain       <= '0;
      ct_reg      <= '0;
      mode_reg    <= 1'b0;
      cnt         <= '0;
    end else begin
      dec_en <= 1'b0;
      if (state != IDLE && any_wr)
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (iv_we)
            chain <= iv_data;
          // rk_we wins over key_done: a partial reload must not look complete
          if (rk_we)
            key_ready <= 1'b0;
          else if (key_done)
            key_ready <= 1'b1;
          if (accept) begin
            ct_reg   <= strm.in_data;
            mode_reg <= cbc_en;
            cnt      <= '0;
            dec_en   <= 1'b1;
            state    <= START;
          end
        end
        START: state <= BUSY;
        BUSY: begin
          if (dec_done) begin
            out_data_r  <= dec_pt ^ (mode_reg ? chain : '0);
            if (mode_reg)
              chain <= ct_reg;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (strm.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_dec_sched.sv
// Bench for aes_dec_sched: a behavioural AES-128 decipher core stub fetches
// round keys from the scheduler; a scoreboard queue holds expected plaintext
// and a monitor compares every output handshake.
module tb_aes_dec_sched;
  localparam int BLK_S   = 128;
  localparam int NR      = 10;
  localparam int RN_W    = 4;
  localparam int TIMEOUT = 32;

  logic              clk;
  logic              reset;
  logic              rk_we;
  logic [RN_W-1:0]   rk_addr;
  logic [BLK_S-1:0]  rk_data;
  logic              key_done;
  logic              key_ready;
  logic              iv_we;
  logic [BLK_S-1:0]  iv_data;
  logic              cbc_en;
  logic              dec_en;
  logic [BLK_S-1:0]  dec_ct;
  logic [RN_W-1:0]   dec_round_no;
  logic [BLK_S-1:0]  dec_round_key;
  logic [BLK_S-1:0]  dec_pt;
  logic              dec_done;
  logic              err;

  aes_dec_sched_if #(.BLK_S(BLK_S)) strm ();

  aes_dec_sched #(.BLK_S(BLK_S), .NR(NR), .RN_W(RN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .rk_we(rk_we), .rk_addr(rk_addr), .rk_data(rk_data),
    .key_done(key_done), .key_ready(key_ready),
    .iv_we(iv_we), .iv_data(iv_data), .cbc_en(cbc_en),
    .strm(strm),
    .dec_en(dec_en), .dec_ct(dec_ct), .dec_round_no(dec_round_no),
    .dec_round_key(dec_round_key), .dec_pt(dec_pt), .dec_done(dec_done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;
  logic [127:0] exp_q [$];
  logic [127:0] rk_model [NR+1];
  logic [127:0] mchain = '0;
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];
  bit core_mute = 0;
  int core_extra = 0;
  bit bp_rand = 0;
  bit or_level = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- AES-128 reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
  endtask

  // One step of the inverse cipher using the key for round r (NR first, 0 last).
  function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] key, input int r);
    logic [7:0] a [16];
    logic [7:0] t [16];
    logic [127:0] o;
    if (r == NR) return st ^ key;
    for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        t[4*c+row] = isbox_t[a[4*((c-row+4)%4)+row]];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    o = o ^ key;
    if (r != 0) begin
      for (int i = 0; i < 16; i++) a[i] = o[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
        t[4*c]   = gmul(a[4*c],8'h0e) ^ gmul(a[4*c+1],8'h0b) ^ gmul(a[4*c+2],8'h0d) ^ gmul(a[4*c+3],8'h09);
        t[4*c+1] = gmul(a[4*c],8'h09) ^ gmul(a[4*c+1],8'h0e) ^ gmul(a[4*c+2],8'h0b) ^ gmul(a[4*c+3],8'h0d);
        t[4*c+2] = gmul(a[4*c],8'h0d) ^ gmul(a[4*c+1],8'h09) ^ gmul(a[4*c+2],8'h0e) ^ gmul(a[4*c+3],8'h0b);
        t[4*c+3] = gmul(a[4*c],8'h0b) ^ gmul(a[4*c+1],8'h0d) ^ gmul(a[4*c+2],8'h09) ^ gmul(a[4*c+3],8'h0e);
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    end
    return o;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= NR; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_pt(input logic [127:0] ct, input bit cbc);
    logic [127:0] s;
    s = ct;
    for (int r = NR; r >= 0; r--) s = inv_round(s, rk_model[r], r);
    return s ^ (cbc ? mchain : 128'h0);
  endfunction

  // ---------------- decipher core stub ----------------
  logic [127:0] core_st;
  initial begin
    dec_round_no = 4'hF;
    dec_done = 1'b0;
    dec_pt = '0;
    forever begin
      step();
      if (dec_en === 1'b1 && reset === 1'b0) begin
        core_st = dec_ct;
        dec_round_no = RN_W'(NR);
        for (int r = NR; r >= 0; r--) begin
          step();
          core_st = inv_round(core_st, dec_round_key, r);
          dec_round_no = (r > 0) ? RN_W'(r - 1) : 4'hF;
        end
        for (int k = 0; k < core_extra; k++) step();
        if (!core_mute) begin
          dec_pt = core_st;
          dec_done = 1'b1;
          step();
          dec_done = 1'b0;
        end
      end
    end
  end

  // ---------------- downstream ready ----------------
  initial begin
    strm.out_ready = 1'b1;
    forever begin
      step();
      strm.out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : or_level;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset === 1'b0 && strm.out_valid === 1'b1 && strm.out_ready === 1'b1) begin
      xfer_cnt++;
      if (exp_q.size() == 0)
        check("unexpected_out", strm.out_data, 128'h0 ^ {128{1'bx}});
      else
        check("out_data", strm.out_data, exp_q.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_keys(input logic [127:0] key);
    expand_key(key);
    for (int r = 0; r <= NR; r++) begin
      rk_we = 1'b1; rk_addr = RN_W'(r); rk_data = rk_model[r];
      step();
    end
    rk_we = 1'b0;
    key_done = 1'b1;
    step();
    key_done = 1'b0;
  endtask

  task automatic set_iv(input logic [127:0] iv);
    iv_we = 1'b1; iv_data = iv;
    step();
    iv_we = 1'b0;
    mchain = iv;
  endtask

  task automatic send(input logic [127:0] ct, input bit cbc, input logic [127:0] exp, input bit push);
    int n;
    n = 0;
    strm.in_valid = 1'b1; strm.in_data = ct; cbc_en = cbc;
    while (strm.in_ready !== 1'b1 && n < 300) begin step(); n++; end
    if (n >= 300) begin
      check("accept_wait", {127'h0, strm.in_ready}, 128'h1);
      strm.in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(exp);
    if (cbc) mchain = ct;
    step();
    strm.in_valid = 1'b0;
    check("dec_en_a1", {127'h0, dec_en}, 128'h1);
    step();
    check("dec_en_a2", {127'h0, dec_en}, 128'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin step(); n++; end
    check("drain", 128'(exp_q.size()), 128'h0);
    repeat (3) step();
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] ct, exp, held;
    bit cbc;
    int viol, x0, ov;

    reset = 1'b1; rk_we = 0; rk_addr = '0; rk_data = '0; key_done = 0;
    iv_we = 0; iv_data = '0; cbc_en = 0; strm.in_valid = 0; strm.in_data = '0;
    build_sbox();
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_key_ready", {127'h0, key_ready}, 128'h0);
    check("rst_in_ready", {127'h0, strm.in_ready}, 128'h0);
    check("rst_out_valid", {127'h0, strm.out_valid}, 128'h0);
    check("rst_dec_en", {127'h0, dec_en}, 128'h0);
    check("rst_err", {127'h0, err}, 128'h0);
    check("rst_out_data", strm.out_data, 128'h0);
    check("rst_dec_ct", dec_ct, 128'h0);

    // FIPS-197 C.1, ECB
    load_keys(FIPS_KEY);
    check("key_ready_set", {127'h0, key_ready}, 128'h1);
    rk_we = 1'b1; rk_addr = 4'd3; rk_data = rk_model[3]; key_done = 1'b1;
    step();
    rk_we = 1'b0; key_done = 1'b0;
    check("key_we_done_same", {127'h0, key_ready}, 128'h0);
    check("in_ready_nokey", {127'h0, strm.in_ready}, 128'h0);
    key_done = 1'b1; step(); key_done = 1'b0;
    check("key_ready_again", {127'h0, key_ready}, 128'h1);
    send(FIPS_CT, 1'b0, FIPS_PT, 1'b1);
    drain();
    check("rk_out_of_range", dec_round_key, 128'h0);
    check("fips_err", {127'h0, err}, 128'h0);

    // SP800-38A CBC
    load_keys(128'h2b7e151628aed2a6abf7158809cf4f3c);
    set_iv(128'h000102030405060708090a0b0c0d0e0f);
    send(128'h7649abac8119b246cee98e9b12e9197d, 1'b1, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b1);
    send(128'h5086cb9b507219ee95db113a917678b2, 1'b1, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1);
    drain();

    // random mixed ECB/CBC with random core latency and random backpressure
    load_keys({$urandom, $urandom, $urandom, $urandom});
    set_iv({$urandom, $urandom, $urandom, $urandom});
    bp_rand = 1;
    for (int i = 0; i < 12; i++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      cbc = 1'($urandom_range(0, 1));
      core_extra = $urandom_range(0, 12);
      exp = model_pt(ct, cbc);
      send(ct, cbc, exp, 1'b1);
    end
    drain();
    bp_rand = 0; or_level = 0; core_extra = 0;
    repeat (2) step();

    // backpressure: 20 stalled cycles
    ct = {$urandom, $urandom, $urandom, $urandom};
    exp = model_pt(ct, 1'b0);
    send(ct, 1'b0, exp, 1'b1);
    x0 = 0;
    while (strm.out_valid !== 1'b1 && x0 < 100) begin step(); x0++; end
    check("bp_out_valid", {127'h0, strm.out_valid}, 128'h1);
    held = strm.out_data;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (strm.out_valid !== 1'b1 || strm.out_data !== held || strm.in_ready !== 1'b0 || dec_en !== 1'b0)
        viol++;
    end
    check("bp_hold", 128'(viol), 128'h0);
    x0 = xfer_cnt;
    or_level = 1;
    repeat (5) step();
    check("bp_one_xfer", 128'(xfer_cnt - x0), 128'h1);
    drain();

    // illegal key write while BUSY
    ct = {$urandom, $urandom, $urandom, $urandom};
    exp = model_pt(ct, 1'b1);
    send(ct, 1'b1, exp, 1'b1);
    rk_we = 1'b1; rk_addr = 4'd5; rk_data = {$urandom, $urandom, $urandom, $urandom};
    step();
    rk_we = 1'b0;
    check("err_illegal", {127'h0, err}, 128'h1);
    drain();

    reset = 1'b1; step(); reset = 1'b0;
    mchain = '0;
    load_keys(FIPS_KEY);

    // timeout: core never completes
    core_mute = 1;
    send(FIPS_CT, 1'b0, 128'h0, 1'b0);
    ov = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin step(); if (strm.out_valid === 1'b1) ov++; end
    check("to_not_early", {127'h0, err}, 128'h0);
    step();
    check("to_err", {127'h0, err}, 128'h1);
    check("to_in_ready", {127'h0, strm.in_ready}, 128'h1);
    check("to_no_out", 128'(ov), 128'h0);
    core_mute = 0;
    repeat (3) step();

    // reset mid-BUSY, late dec_done must be ignored
    send(FIPS_CT, 1'b0, 128'h0, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    check("rst_comb_in_ready", {127'h0, strm.in_ready}, 128'h0);
    step();
    reset = 1'b0;
    check("mid_rst_out_valid", {127'h0, strm.out_valid}, 128'h0);
    check("mid_rst_dec_en", {127'h0, dec_en}, 128'h0);
    check("mid_rst_err", {127'h0, err}, 128'h0);
    check("mid_rst_key_ready", {127'h0, key_ready}, 128'h0);
    check("mid_rst_out_data", strm.out_data, 128'h0);
    check("mid_rst_dec_ct", dec_ct, 128'h0);
    ov = 0;
    for (int i = 0; i < 20; i++) begin step(); if (strm.out_valid === 1'b1) ov++; end
    check("late_done_ignored", 128'(ov), 128'h0);
    mchain = '0;
    load_keys(FIPS_KEY);
    send(FIPS_CT, 1'b0, FIPS_PT, 1'b1);
    drain();
    check("final_err", {127'h0, err}, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_dec_sched.md
Name: aes_dec_sched

Overview:
Sequencing controller for the iterative AES-128 decipher core. It owns the round-key store (Nr+1 entries, loaded by key expansion) and accepts ciphertext blocks over a valid/ready stream. It starts the core, serves each round key by round number and applies optional CBC chaining before returning plaintext on a valid/ready stream.
It sits between the DMA/stream glue and the decipher core.

Parameters:
BLK_S, 128, block/round-key width in bits
NR, 10, number of rounds; the key store has NR+1 entries
RN_W, 4, round-number width
TIMEOUT, 32, maximum cycles from dec_en to dec_done before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rk_we  in  1  round-key write strobe
rk_addr  in  RN_W  round-key index 0..NR
rk_data  in  BLK_S  round-key value
key_done  in  1  pulse: key store complete, sets key_ready
key_ready  out  1  keys valid, blocks may be accepted
iv_we  in  1  load chain register with iv_data
iv_data  in  BLK_S  CBC initialisation vector
cbc_en  in  1  1=CBC decrypt, 0=ECB; sampled at acceptance
in_valid  in  1  ciphertext valid
in_ready  out  1  ciphertext accepted when in_valid&&in_ready
in_data  in  BLK_S  ciphertext
out_valid  out  1  plaintext valid
out_ready  in  1  downstream ready
out_data  out  BLK_S  plaintext
dec_en  out  1  one-cycle start pulse to core
dec_ct  out  BLK_S  ciphertext to core, held stable while busy
dec_round_no  in  RN_W  core's current round number
dec_round_key  out  BLK_S  round key to core
dec_pt  in  BLK_S  core result
dec_done  in  1  core result-valid pulse
err  out  1  sticky: illegal write or timeout

Behaviour:
- Reset: state=IDLE; key_ready, in_ready, out_valid, dec_en and err are 0; out_data, chain and the ciphertext register are 0. The key store is not cleared; key_ready=0 forces a reload. A reset in any state aborts the block in flight with no output. Core results arriving after the abort are ignored.
- dec_round_key is a registered read of key_mem[dec_round_no], one-cycle latency, every cycle regardless of state. An out-of-range index (>NR) returns 0.
- Key writes (rk_we, iv_we, key_done) take effect only in IDLE. In any other state the write is dropped and err is set.
  - rk_we clears key_ready.
  - key_done sets key_ready.
  - If rk_we and key_done occur in the same cycle, key_ready ends at 0.
- in_ready = (state==IDLE) && key_ready && !reset. It is combinational from registered state.
- FSM:
  - IDLE: on acceptance, latch in_data into ct_reg and cbc_en into mode_reg, clear the timeout counter, go to START.
  - START: dec_en=1 for this cycle only; go to BUSY.
  - BUSY: the counter increments each cycle.
    - On dec_done: out_data <= dec_pt ^ (mode_reg ? chain : 0). If mode_reg, chain <= ct_reg. out_valid <= 1; go to OUT.
    - If the counter reaches TIMEOUT without dec_done: err <= 1, go to IDLE with no output, chain unchanged.
  - OUT: hold out_valid/out_data until out_ready. On the handshake cycle, out_valid <= 0 and go to IDLE.
- dec_done outside BUSY is ignored.
- dec_ct = ct_reg.
- Latency: acceptance edge A → dec_en high in cycle A+1 → out_valid rises the cycle after dec_done is sampled.
- Throughput: one block per (core latency + 3) cycles; no overlap.
- ECB blocks never modify chain. Mixing ECB and CBC blocks is legal.
- out_ready held high: OUT lasts exactly one cycle. Backpressure stalls indefinitely with no data loss.

Test Plan:
- FIPS-197 C.1: load expanded key 000102…0f, then key_done; ECB ct 69c4e0d86a7b0430d8cdb78070b4c55a → out_data 00112233445566778899aabbccddeeff. dec_en is one cycle at A+1; err=0.
- SP800-38A CBC: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102…0f.
  - Ciphertext stream 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2.
  - Expected plaintext 6bc1bee22e409f96e93d7e117393172a, then ae2d8a571e03ac9c9eb76fac45af8e51.
- Backpressure: out_ready=0 for 20 cycles. out_valid and out_data stay stable, in_ready=0 throughout, no second dec_en; release → exactly one transfer.
- Illegal write: rk_we pulse during BUSY → err=1, key store unchanged, the current block still decrypts correctly.
- Timeout: stub core never asserts dec_done → err=1 at TIMEOUT cycles after dec_en, return to IDLE with in_ready=1 and out_valid never asserted.
- Reset mid-BUSY: assert reset for 1 cycle → all outputs 0, key_ready=0, a late dec_done is ignored; after reload and key_done, a FIPS vector decrypts correctly.
